int_to_ascii: RTL and testbench
===============================

INT_TO_ASCII -- requirements
Module: int_to_ascii

Interface
REQ-001 Parameter N, default 16, width of the signed input value (two's complement), same meaning as the evaluator result width.
REQ-002 Parameter LEN, default 100, length in bytes of the packed string output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request; captures value and ovf_in when idle.
REQ-006 value  input  N  signed integer to format.
REQ-007 ovf_in  input  1  evaluator overflow flag; when set, the string "OVF" is formatted instead of value.
REQ-008 out_char  output  8  current ASCII character of the stream.
REQ-009 out_valid  output  1  out_char is valid.
REQ-010 out_ready  input  1  consumer accepts out_char; a transfer occurs when out_valid and out_ready are both high at a rising edge.
REQ-011 out_last  output  1  high with the final character of the string.
REQ-012 busy  output  1  high from the cycle after an accepted start until the cycle after the last transfer.
REQ-013 str  output  8*LEN  packed string: first character in bits [8*LEN-1:8*LEN-8], remaining bytes 8'h00; valid while done is high.
REQ-014 done  output  1  high from the cycle after the last transfer until the next accepted start.

Function
REQ-015 FSM states: IDLE, LOAD, DIV, PUSH, EMIT, DONE; DONE behaves as IDLE for start acceptance.
REQ-016 start is accepted only in IDLE or DONE; start while busy is ignored with no effect.
REQ-017 LOAD: mag = |value| as N-bit unsigned (value = -2^(N-1) gives 2^(N-1) with no overflow); neg = value[N-1]; digit stack and str are cleared.
REQ-018 DIV: serial restoring division of mag by 10, one quotient bit per cycle, N cycles per digit.
REQ-019 PUSH: remainder + 8'h30 pushed onto the LIFO digit stack; mag = quotient; returns to DIV if quotient != 0, else goes to EMIT. Value 0 therefore yields exactly one digit, "0".
REQ-020 Digit stack depth D = ((N-1)*30103)/100000 + 1 (5 for N=16); overflow of the stack is impossible by construction.
REQ-021 EMIT order: '-' (8'h2D) first if neg, then digits most-significant first; no leading zeros, no '+'.
REQ-022 ovf_in set: LOAD/DIV/PUSH are bypassed and EMIT streams 'O','V','F'.
REQ-023 out_char holds stable while out_valid is high and out_ready is low; the stream advances one character per transfer, so throughput is 1 char/cycle under continuous ready.
REQ-024 out_last is high only with the final character; after its transfer the FSM enters DONE and out_valid drops in the next cycle.
REQ-025 Each transferred character is also written into str at the next byte position, MSB first; str is stable in DONE.
REQ-026 Latency start -> first out_valid for a k-digit value is 1 + k*(N+1) + 1 cycles; for ovf_in it is 2 cycles.
REQ-027 str requires LEN >= D+1; this is checked by an elaboration-time assertion.

Reset
REQ-028 rst_n low at a clock edge forces IDLE from any state, including mid-DIV or mid-EMIT; any partial stream is abandoned.
REQ-029 Reset values: out_char 8'h00, out_valid 0, out_last 0, busy 0, done 0, str all 8'h00; digit stack and divider registers are cleared.

Structure
REQ-030 The shared package evalpost_pkg holds the FSM state enum, the ASCII constants (ZERO 8'h30, MINUS 8'h2D, NUL 8'h00, 'O','V','F') and a digit-count function giving D.
REQ-031 The serial divider is the sub-module udiv10_serial (ports: clk, rst_n, go, dividend[N-1:0], quotient, remainder[3:0], ready).

Verification
REQ-032 value = -323, out_ready held high -> stream '-','3','2','3'; out_last on the '3' in position 4; str = "-323" followed by NULs; first out_valid 1+3*17+1 = 53 cycles after start.
REQ-033 value = 0 -> single '0' with out_last; value = 32767 -> "32767"; value = -32768 -> "-32768".
REQ-034 ovf_in = 1 with any value -> "OVF" streamed, with out_last on 'F'.
REQ-035 value = 1205 with out_ready toggled 1,0,0,1,... -> out_char stable across stalls, no character lost or duplicated, str = "1205".
REQ-036 rst_n low for one cycle during EMIT of "-323" after 2 transfers -> next cycle all outputs at reset values; a following start with value 7 -> clean "7".
REQ-037 start pulsed again mid-DIV with a different value -> ignored; original value's string produced.

Source files
------------

// File: rtl/evalpost_pkg.sv
// Shared definitions for the evaluator post-processing path:
// formatter FSM states, ASCII constants and digit-stack sizing.
package evalpost_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        PUSH,
        EMIT,
        DONE
    } state_t;

    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] MINUS = 8'h2D;
    localparam logic [7:0] NUL   = 8'h00;
    localparam logic [7:0] CH_O  = 8'h4F;
    localparam logic [7:0] CH_V  = 8'h56;
    localparam logic [7:0] CH_F  = 8'h46;

    // Decimal digits needed for 2^(n-1), using log10(2) ~= 0.30103.
    function automatic int digit_count(input int n);
        return ((n - 1) * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/udiv10_serial.sv
// Serial restoring divide-by-10: one quotient bit per cycle, N cycles total.
// The first step is taken on the go edge itself; ready is high once all N steps are done.
module udiv10_serial #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [N-1:0] dividend,
    output logic [N-1:0] quotient,
    output logic [3:0]   remainder,
    output logic         ready
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt;
    logic [3:0]    rem_src;
    logic [3:0]    rem_nx;
    logic [N-1:0]  quo_src;
    logic [N-1:0]  quo_nx;
    logic [4:0]    trial;

    // quotient doubles as the shift register: dividend bits leave at the top,
    // quotient bits enter at the bottom.
    always_comb begin
        rem_src = go ? 4'h0 : remainder;
        quo_src = go ? dividend : quotient;
        trial   = {rem_src, quo_src[N-1]};
        if (trial >= 5'd10) begin
            rem_nx = 4'(trial - 5'd10);
            quo_nx = {quo_src[N-2:0], 1'b1};
        end else begin
            rem_nx = trial[3:0];
            quo_nx = {quo_src[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (go) begin
            quotient  <= quo_nx;
            remainder <= rem_nx;
            cnt       <= CW'(N - 1);
        end else if (cnt != '0) begin
            quotient  <= quo_nx;
            remainder <= rem_nx;
            cnt       <= cnt - CW'(1);
        end
    end

    assign ready = (cnt == '0);

endmodule

// File: rtl/int_to_ascii.sv
// Formats a signed N-bit result (or "OVF") as a decimal ASCII stream with
// valid/ready handshake, and also collects it into a packed string.
module int_to_ascii
    import evalpost_pkg::*;
#(
    parameter int N   = 16,
    parameter int LEN = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     value,
    input  logic             ovf_in,
    output logic [7:0]       out_char,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic [8*LEN-1:0] str,
    output logic             done
);

    localparam int D   = digit_count(N);
    localparam int SD  = (D < 3) ? 3 : D;
    localparam int SPW = $clog2(SD + 1);
    localparam int WPW = $clog2(LEN + 1);

    if (LEN < D + 1) begin : g_len_chk
        $error("int_to_ascii: LEN must be at least D+1");
    end

    state_t         state;
    state_t         state_nx;
    logic [N-1:0]   value_q;
    logic [N-1:0]   mag;
    logic [N-1:0]   dividend;
    logic [N-1:0]   quotient;
    logic [3:0]     remainder;
    logic           ovf_q;
    logic           neg;
    logic [7:0]     stack [SD];
    logic [SPW-1:0] sp;
    logic [WPW-1:0] wpos;
    logic           div_go;
    logic           div_ready;
    logic           accept;
    logic           last_char;
    logic [7:0]     cur_char;

    assign accept    = ((state == IDLE) || (state == DONE)) && start;
    assign mag       = value_q[N-1] ? -value_q : value_q;
    assign dividend  = (state == LOAD) ? mag : quotient;
    assign div_go    = ((state == LOAD) && !ovf_q) || ((state == PUSH) && (quotient != '0));
    // neg stays set until the '-' has been transferred, then digits pop off the stack.
    assign cur_char  = neg ? MINUS : stack[sp - SPW'(1)];
    assign last_char = !neg && (sp == SPW'(1));

    udiv10_serial #(.N(N)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (div_go),
        .dividend  (dividend),
        .quotient  (quotient),
        .remainder (remainder),
        .ready     (div_ready)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = LOAD;
            LOAD:       state_nx = ovf_q ? EMIT : DIV;
            DIV:        if (div_ready) state_nx = PUSH;
            PUSH:       state_nx = (quotient != '0) ? DIV : EMIT;
            EMIT:       if (out_ready && last_char) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_char  = NUL;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            LOAD, DIV, PUSH: busy = 1'b1;
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_char  = cur_char;
                out_last  = last_char;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
            neg     <= 1'b0;
            sp      <= '0;
            wpos    <= '0;
            str     <= '0;
            for (int unsigned i = 0; i < SD; i++) stack[i] <= NUL;
        end else begin
            if (accept) begin
                value_q <= value;
                ovf_q   <= ovf_in;
            end
            case (state)
                LOAD: begin
                    str  <= '0;
                    wpos <= '0;
                    for (int unsigned i = 0; i < SD; i++) stack[i] <= NUL;
                    // "OVF" is preloaded as a 3-deep stack so EMIT needs no special case.
                    if (ovf_q) begin
                        neg      <= 1'b0;
                        stack[2] <= CH_O;
                        stack[1] <= CH_V;
                        stack[0] <= CH_F;
                        sp       <= SPW'(3);
                    end else begin
                        neg <= value_q[N-1];
                        sp  <= '0;
                    end
                end
                PUSH: begin
                    stack[sp] <= ZERO + {4'h0, remainder};
                    sp        <= sp + SPW'(1);
                end
                EMIT: begin
                    if (out_ready) begin
                        for (int unsigned i = 0; i < LEN; i++) begin
                            if (wpos == WPW'(i)) str[8*(LEN-1-i) +: 8] <= cur_char;
                        end
                        wpos <= wpos + WPW'(1);
                        if (neg) neg <= 1'b0;
                        else     sp  <= sp - SPW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_ascii.sv
// Self-checking bench for int_to_ascii: expected characters are queued when a
// request is issued and popped as the DUT transfers them.
module tb_int_to_ascii;

    localparam int N   = 16;
    localparam int LEN = 100;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [N-1:0]     value;
    logic             ovf_in;
    logic [7:0]       out_char;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic [8*LEN-1:0] str;
    logic             done;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sbq [$];
    int         cyc = 0;
    int         start_cyc = 0;
    int         first_lat = -1;
    int         xfer_cnt = 0;
    int         ph = 0;
    bit         stall_mode = 1'b0;
    bit         mon_en = 1'b1;
    bit         held_valid = 1'b0;
    logic [7:0] held_char = 8'h00;

    always #5 clk = ~clk;

    int_to_ascii #(.N(N), .LEN(LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .value     (value),
        .ovf_in    (ovf_in),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .str       (str),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive ready for the coming edge, then score any transfer it will make.
    task automatic tick();
        @(negedge clk);
        cyc++;
        out_ready = stall_mode ? (ph % 3 == 0) : 1'b1;
        ph++;
        if (out_valid && first_lat < 0) first_lat = cyc - start_cyc;
        if (mon_en) begin
            if (held_valid) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", out_char, held_char);
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    check("char", out_char, sbq.pop_front());
                    check("last", out_last, sbq.size() == 0);
                end
                xfer_cnt++;
            end
        end
        held_valid = out_valid && !out_ready;
        held_char  = out_char;
    endtask

    task automatic expect_str(input string s, output logic [63:0] head);
        head = '0;
        for (int i = 0; i < s.len(); i++) begin
            sbq.push_back(s[i]);
            head[63-8*i -: 8] = s[i];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_char"},  out_char, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"},  out_last, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_str"},   |str, 0);
    endtask

    task automatic run(input logic [N-1:0] v, input logic ovf, input bit stall,
                       input int restart_at, input string s);
        logic [63:0] head;
        int k;
        int lat;
        int guard;
        expect_str(s, head);
        k   = (s[0] == 8'h2D) ? s.len() - 1 : s.len();
        lat = ovf ? 2 : 2 + k * (N + 1);
        stall_mode = stall;
        ph         = 0;
        first_lat  = -1;
        xfer_cnt   = 0;
        value      = v;
        ovf_in     = ovf;
        start      = 1'b1;
        start_cyc  = cyc;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        guard = 0;
        while (!done && guard < 3000) begin
            if (guard == restart_at) begin
                value  = ~v;
                ovf_in = 1'b0;
                start  = 1'b1;
            end
            tick();
            start = 1'b0;
            guard++;
        end
        check("done_reached", done, 1);
        check("queue_drained", sbq.size(), 0);
        check("latency", first_lat, lat);
        check("str_head", str[8*LEN-1 -: 64], head);
        check("str_tail", |str[8*LEN-65:0], 0);
        check("valid_in_done", out_valid, 0);
        check("busy_in_done", busy, 0);
        sbq.delete();
    endtask

    initial begin
        logic [63:0]  head;
        logic [N-1:0] v;
        int           guard;

        rst_n     = 1'b0;
        start     = 1'b0;
        value     = '0;
        ovf_in    = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        run(-16'sd323,  1'b0, 1'b0, -1, "-323");
        run(16'd0,      1'b0, 1'b0, -1, "0");
        run(16'd32767,  1'b0, 1'b0, -1, "32767");
        run(16'h8000,   1'b0, 1'b0, -1, "-32768");
        run(16'h1234,   1'b1, 1'b0, -1, "OVF");
        run(16'd1205,   1'b0, 1'b1, -1, "1205");
        run(16'd4095,   1'b0, 1'b0,  5, "4095");
        for (int i = 0; i < 6; i++) begin
            v = N'($urandom);
            run(v, 1'b0, i[0], -1, $sformatf("%0d", $signed(v)));
        end

        // Reset in the middle of streaming "-323".
        expect_str("-323", head);
        stall_mode = 1'b0;
        xfer_cnt   = 0;
        first_lat  = -1;
        value      = -16'sd323;
        ovf_in     = 1'b0;
        start      = 1'b1;
        start_cyc  = cyc;
        tick();
        start = 1'b0;
        guard = 0;
        while (xfer_cnt < 2 && guard < 3000) begin
            tick();
            guard++;
        end
        check("two_transfers", xfer_cnt, 2);
        mon_en = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        sbq.delete();
        mon_en     = 1'b1;
        held_valid = 1'b0;
        run(16'd7, 1'b0, 1'b0, -1, "7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
